// File: rtl/soluzione_pkg.sv
// Shared constants and helpers for the soluzione ripple-carry adder.
package soluzione_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Signed overflow happens when the carry into the MSB differs from the carry out of it.
    function automatic logic signed_ovf(input logic carry_msb_in, input logic carry_msb_out);
        signed_ovf = carry_msb_in ^ carry_msb_out;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder: the cell repeated along the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_s;

    assign half_s = a ^ b;
    assign s      = half_s ^ cin;
    assign cout   = (a & b) | (cin & half_s);

endmodule

// File: rtl/soluzione.sv
// WIDTH-bit ripple-carry adder with registered sum, unsigned carry and signed overflow.
module soluzione
    import soluzione_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] S,
    output logic             c_out,
    output logic             ow
);

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;
    logic             ovf_s;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             ow_r;

    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a    (X[i]),
            .b    (Y[i]),
            .cin  (carry_s[i]),
            .s    (sum_s[i]),
            .cout (carry_s[i+1])
        );
    end

    assign ovf_s = signed_ovf(carry_s[WIDTH-1], carry_s[WIDTH]);

    // Output register bank; cleared asynchronously so outputs are never X after reset.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            sum_r   <= {WIDTH{1'b0}};
            c_out_r <= 1'b0;
            ow_r    <= 1'b0;
        end else begin
            sum_r   <= sum_s;
            c_out_r <= carry_s[WIDTH];
            ow_r    <= ovf_s;
        end
    end

    assign S     = sum_r;
    assign c_out = c_out_r;
    assign ow    = ow_r;

endmodule

// File: tb/tb_soluzione.sv
// Directed and random bench for soluzione using a queue of expected results.
module tb_soluzione;

    typedef struct packed {
        logic       c;
        logic       o;
        logic [7:0] s;
    } res_t;

    logic       clock;
    logic       reset_;
    logic [7:0] X;
    logic [7:0] Y;
    logic [7:0] S;
    logic       c_out;
    logic       ow;

    int   vectors    = 0;
    int   miscompares = 0;
    res_t exp_q[$];
    res_t prev_exp;
    bit   have_prev  = 1'b0;

    soluzione #(.WIDTH(8)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .X      (X),
        .Y      (Y),
        .S      (S),
        .c_out  (c_out),
        .ow     (ow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic res_t model(input logic [7:0] x, input logic [7:0] y);
        logic [8:0] full;
        res_t r;
        full = {1'b0, x} + {1'b0, y};
        r.s  = full[7:0];
        r.c  = full[8];
        r.o  = (x[7] == y[7]) && (full[7] != x[7]);
        return r;
    endfunction

    task automatic compare(input string tag, input res_t expv);
        res_t obs;
        obs = {c_out, ow, S};
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed S=%h c_out=%b ow=%b, expected S=%h c_out=%b ow=%b",
                   tag, obs.s, obs.c, obs.o, expv.s, expv.c, expv.o);
        end
    endtask

    // Drive one operand pair, confirm the previous result is still held, then check after the edge.
    task automatic cycle(input logic [7:0] x, input logic [7:0] y, input string tag);
        res_t got;
        X = x;
        Y = y;
        exp_q.push_back(model(x, y));
        if (have_prev) begin
            #1;
            compare({tag, "_hold"}, prev_exp);
        end
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: scoreboard empty, observed S=%h", tag, S);
        end else begin
            got = exp_q.pop_front();
            compare(tag, got);
            prev_exp  = got;
            have_prev = 1'b1;
        end
    endtask

    initial begin
        res_t zero_r;
        zero_r = '{c: 1'b0, o: 1'b0, s: 8'h00};

        reset_ = 1'b0;
        X = 8'hFF;
        Y = 8'hFF;
        #2;
        compare("reset_no_edge", zero_r);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            X = ~X;
            Y = 8'($urandom);
            #1;
            compare("reset_held", zero_r);
        end

        reset_ = 1'b1;
        cycle(8'hFF, 8'hFF, "release_ff_ff");
        cycle(8'h00, 8'h08, "plain_add");
        cycle(8'h80, 8'h80, "both_flags");
        cycle(8'h40, 8'h40, "ovf_only");
        cycle(8'hFF, 8'h01, "carry_only");
        for (int i = 1; i <= 16; i++) begin
            cycle(8'(i), 8'h10, "ladder");
        end

        // Reset between edges must clear at once; the next edge uses the operands present then.
        reset_ = 1'b0;
        #1;
        compare("reset_mid_op", zero_r);
        reset_ = 1'b1;
        exp_q.delete();
        have_prev = 1'b0;
        cycle(8'h12, 8'h34, "after_mid_reset");
        cycle(8'h7F, 8'h01, "ovf_7f_01");

        for (int i = 0; i < 1000; i++) begin
            cycle(8'($urandom), 8'($urandom), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
